imem_fetch_responder: RTL and testbench

//  Instruction-memory responder: the far end of the fetch interface driven by the PC register.

---
 rtl/imem_fetch_responder.sv | 84 ++++++++
 tb/tb_imem_fetch_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction-memory fetch responder with fixed read latency and credit-limited response FIFO
module imem_fetch_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);
  localparam int D = LATENCY + 1;
  localparam int CW = $clog2(D + 1);
  typedef struct packed {
    logic [31:0]       addr;
    logic              err;
    logic [DATA_W-1:0] data;
  } ent_t;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  ent_t acc_e, in_e;
  ent_t fifo_q [D];
  ent_t fifo_d [D];
  logic [CW-1:0] occ_q, occ_d, cnt_q, cnt_d, wi;
  logic acc, pop, in_v, oor;
  assign req_ready = (cnt_q < CW'(D)) && !rst;
  assign acc = req_valid && req_ready;
  assign rsp_valid = occ_q != '0;
  assign pop = rsp_valid && rsp_ready && !flush;
  assign rsp_addr = fifo_q[0].addr;
  assign rsp_err = fifo_q[0].err;
  assign rsp_data = fifo_q[0].data;
  assign oor = |(req_addr >> ADDR_W);
  assign acc_e = '{addr: req_addr, err: oor, data: oor ? NOP_WORD : mem[req_addr[ADDR_W-1:0]]};
  if (LATENCY == 1) begin : g_direct
    assign in_v = acc;
    assign in_e = acc_e;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q, pv_d;
    ent_t pe_q [LATENCY-1];
    ent_t pe_d [LATENCY-1];
    always_comb begin
      pv_d[0] = acc;
      pe_d[0] = acc_e;
      for (int i = 1; i < LATENCY - 1; i++) begin
        pv_d[i] = pv_q[i-1] && !flush;
        pe_d[i] = pe_q[i-1];
      end
    end
    always_ff @(posedge clk) begin
      pv_q <= rst ? '0 : pv_d;
      pe_q <= pe_d;
    end
    assign in_v = pv_q[LATENCY-2] && !flush;
    assign in_e = pe_q[LATENCY-2];
  end
  always_comb begin
    fifo_d = fifo_q;
    if (pop)
      for (int i = 0; i < D - 1; i++) fifo_d[i] = fifo_q[i+1];
    wi = flush ? '0 : occ_q - CW'(pop);
    for (int i = 0; i < D; i++)
      if (in_v && wi == CW'(i)) fifo_d[i] = in_e;
    occ_d = wi + CW'(in_v);
    cnt_d = flush ? CW'(acc) : cnt_q + CW'(acc) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    occ_q <= rst ? '0 : occ_d;
    cnt_q <= rst ? '0 : cnt_d;
    for (int i = 0; i < D; i++) fifo_q[i] <= rst ? '0 : fifo_d[i];
  end
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: two responders (latency 1 and 3) checked against a timestamped queue model
module tb_imem_fetch_responder;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0, flush = 0, load_en = 0;
  logic [31:0] req_addr = 0, load_data = 0;
  logic [9:0] load_addr = 0;
  logic [1:0] rdy, rv, re;
  logic [31:0] rd [2];
  logic [31:0] ra [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  imem_fetch_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_data(rd[0]), .rsp_addr(ra[0]), .rsp_err(re[0]),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  imem_fetch_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_data(rd[1]), .rsp_addr(ra[1]), .rsp_err(re[1]),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  typedef struct {
    logic [31:0] a;
    logic        e;
    logic [31:0] dat;
    int          rc;
  } ment_t;
  ment_t mq [2][$];
  logic [31:0] mm [1024];
  int cyc = 0;
  logic [1:0] ev, ee;
  logic [31:0] ed [2];
  logic [31:0] ea [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int lat;
      logic ok, vis;
      lat = d ? 3 : 1;
      ok = !rst && mq[d].size() < lat + 1;
      vis = mq[d].size() > 0 && mq[d][0].rc <= cyc;
      if (rst || flush) mq[d].delete();
      else if (vis && rsp_ready) void'(mq[d].pop_front());
      if (req_valid && ok)
        mq[d].push_back('{req_addr, req_addr >= 1024, req_addr >= 1024 ? 32'h13 : mm[req_addr[9:0]], cyc + lat});
    end
    if (load_en) mm[load_addr] = load_data;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      ev[d] = mq[d].size() > 0 && mq[d][0].rc <= cyc;
      if (ev[d]) begin
        ea[d] = mq[d][0].a;
        ee[d] = mq[d][0].e;
        ed[d] = mq[d][0].dat;
      end
    end
  end
  task automatic drive(input logic r, v, input logic [31:0] a, input logic rr, fl, le,
                       input logic [9:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_addr = a; rsp_ready = rr;
    flush = fl; load_en = le; load_addr = la; load_data = ld;
    @(negedge clk);
  endtask
  task automatic preload();
    for (int i = 0; i < 1024; i++) drive(0, 0, 0, 1, 0, 1, 10'(i), $urandom);
  endtask
  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_hs dut%0d valid=%b ready=%b exp valid=0 ready=1", d, rv[d], rdy[d]);
      end
      checks++;
      if (rd[d] !== 32'h0 || ra[d] !== 32'h0 || re[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out dut%0d data=%h addr=%h err=%b exp all zero", d, rd[d], ra[d], re[d]);
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 1, 10'(i), 32'hA0 + 32'(i));
    for (int k = 0; k < 9; k++) begin
      drive(0, k < 4, 32'(k), 1, 0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        logic er;
        er = !rst && mq[d].size() < (d ? 4 : 2);
        checks++;
        if (rv[d] !== ev[d] || rdy[d] !== er) begin
          errors++;
          $display("FAIL b2b_hs dut%0d k=%0d valid=%b ready=%b exp valid=%b ready=%b", d, k, rv[d], rdy[d], ev[d], er);
        end
        if (ev[d]) begin
          checks++;
          if ({ra[d], re[d], rd[d]} !== {ea[d], ee[d], ed[d]}) begin
            errors++;
            $display("FAIL b2b_rsp dut%0d k=%0d got %h/%b/%h exp %h/%b/%h", d, k, ra[d], re[d], rd[d], ea[d], ee[d], ed[d]);
          end
        end
      end
      if (k > 0 && k < 5) begin
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'hA0 + 32'(k - 1) || rdy[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_seq k=%0d valid=%b data=%h ready=%b exp 1/%h/1", k, rv[0], rd[0], rdy[0], 32'hA0 + 32'(k - 1));
        end
      end
    end
  endtask
  task automatic test_backpressure();
    int n0 = 0, n1 = 0, got = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 32'(100 + i), 0, 0, 0, 0, 0);
      n0 += int'(rdy[0]);
      n1 += int'(rdy[1]);
    end
    checks++;
    if (n1 != 4 || n0 != 2) begin
      errors++;
      $display("FAIL bp_accepts got l1=%0d l3=%0d exp l1=2 l3=4", n0, n1);
    end
    checks++;
    if (rv[1] !== 1'b1 || ra[1] !== 32'd100) begin
      errors++;
      $display("FAIL bp_hold valid=%b addr=%h exp 1/%h", rv[1], ra[1], 32'd100);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      if (rv[1]) begin
        checks++;
        if (ra[1] !== 32'(100 + got)) begin
          errors++;
          $display("FAIL bp_order got %h exp %h", ra[1], 32'(100 + got));
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL bp_count got %0d exp 4", got);
    end
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 32'(200 + i), 1, 0, 0, 0, 0);
      n1 += int'(rdy[1]);
    end
    checks++;
    if (n1 != 6) begin
      errors++;
      $display("FAIL bp_resume got %0d accepts exp 6", n1);
    end
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic test_range();
    logic [31:0] tab [3] = '{32'h400, 32'h3FF, 32'hFFFFFFFF};
    for (int k = 0; k < 7; k++) begin
      drive(0, k < 3, k < 3 ? tab[k] : 32'h0, 1, 0, 0, 0, 0);
      if (k > 0 && k < 4) begin
        logic [31:0] a, x;
        logic e;
        a = tab[k-1];
        e = a >= 1024;
        x = e ? 32'h13 : mm[a[9:0]];
        checks++;
        if (rv[0] !== 1'b1 || {ra[0], re[0], rd[0]} !== {a, e, x}) begin
          errors++;
          $display("FAIL range k=%0d got %b %h/%b/%h exp 1 %h/%b/%h", k, rv[0], ra[0], re[0], rd[0], a, e, x);
        end
      end
    end
  endtask
  task automatic test_flush();
    for (int k = 0; k < 17; k++) begin
      logic v;
      logic [31:0] a;
      v = k <= 3 || k == 10 || k == 11;
      a = k < 3 ? 32'(5 + k) : k == 3 ? 32'h20 : k == 10 ? 32'h9 : 32'h30;
      drive(0, v, a, k >= 4, k == 3 || k == 11, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        logic er;
        er = !rst && mq[d].size() < (d ? 4 : 2);
        checks++;
        if (rv[d] !== ev[d] || rdy[d] !== er) begin
          errors++;
          $display("FAIL flush_hs dut%0d k=%0d valid=%b ready=%b exp valid=%b ready=%b", d, k, rv[d], rdy[d], ev[d], er);
        end
        if (ev[d]) begin
          checks++;
          if ({ra[d], re[d], rd[d]} !== {ea[d], ee[d], ed[d]}) begin
            errors++;
            $display("FAIL flush_rsp dut%0d k=%0d got %h/%b/%h exp %h/%b/%h", d, k, ra[d], re[d], rd[d], ea[d], ee[d], ed[d]);
          end
        end
      end
      if (k == 4 || k == 5 || k == 7) begin
        checks++;
        if (rv[1] !== 1'b0 || (k == 4 && rv[0] !== 1'b0)) begin
          errors++;
          $display("FAIL flush_drop k=%0d valid l1=%b l3=%b exp 0", k, rv[0], rv[1]);
        end
      end
      if (k == 6 || k == 12) begin
        checks++;
        if (rv[k == 6] !== 1'b1 || ra[k == 6] !== (k == 6 ? 32'h20 : 32'h30)) begin
          errors++;
          $display("FAIL flush_target k=%0d valid=%b addr=%h exp 1/%h", k, rv[k == 6], ra[k == 6], k == 6 ? 32'h20 : 32'h30);
        end
      end
    end
  endtask
  task automatic test_load_collision();
    for (int k = 0; k < 7; k++) begin
      drive(0, k == 1 || k == 2, 32'h8, 1, 0, k < 2, 10'h8, k == 0 ? 32'h11 : 32'h22);
      if (k == 2 || k == 3 || k == 4 || k == 5) begin
        logic [31:0] x;
        int d;
        d = k >= 4 ? 1 : 0;
        x = (k == 2 || k == 4) ? 32'h11 : 32'h22;
        checks++;
        if (rv[d] !== 1'b1 || rd[d] !== x) begin
          errors++;
          $display("FAIL load_rbw dut%0d k=%0d valid=%b data=%h exp 1/%h", d, k, rv[d], rd[d], x);
        end
      end
    end
  endtask
  task automatic test_reset_midop();
    for (int k = 0; k < 15; k++) begin
      drive(k == 5, k < 3 || k == 10, k == 10 ? 32'h0 : 32'(k), k >= 6, 0, 0, 0, 0);
      if (k >= 6 && k <= 10) begin
        checks++;
        if (rv !== 2'b00 || rdy !== 2'b11) begin
          errors++;
          $display("FAIL rst_mid k=%0d valid=%b ready=%b exp valid=00 ready=11", k, rv, rdy);
        end
      end
      if (k == 11 || k == 13) begin
        checks++;
        if (rv[k == 13] !== 1'b1 || rd[k == 13] !== 32'hA0 || ra[k == 13] !== 32'h0) begin
          errors++;
          $display("FAIL rst_mem k=%0d valid=%b data=%h addr=%h exp 1/%h/0", k, rv[k == 13], rd[k == 13], ra[k == 13], 32'hA0);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 410; i++) begin
      if (i < 400) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = r == 0 ? 32'h400 + 32'($urandom_range(0, 15)) : r == 1 ? $urandom :
            r == 2 ? 32'(1022 + $urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
        drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) != 0 ? a[9:0] : 10'($urandom_range(0, 1023)), $urandom);
      end else drive(0, 0, 0, 1, 0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        logic er;
        er = !rst && mq[d].size() < (d ? 4 : 2);
        checks++;
        if (rv[d] !== ev[d] || rdy[d] !== er) begin
          errors++;
          $display("FAIL rand_hs dut%0d i=%0d valid=%b ready=%b exp valid=%b ready=%b", d, i, rv[d], rdy[d], ev[d], er);
        end
        if (ev[d]) begin
          checks++;
          if ({ra[d], re[d], rd[d]} !== {ea[d], ee[d], ed[d]}) begin
            errors++;
            $display("FAIL rand_rsp dut%0d i=%0d got %h/%b/%h exp %h/%b/%h", d, i, ra[d], re[d], rd[d], ea[d], ee[d], ed[d]);
          end
        end
      end
    end
  endtask
  initial begin
    test_reset();
    preload();
    test_back_to_back();
    test_backpressure();
    test_range();
    test_flush();
    test_load_collision();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
